// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the trace capture block.
//   - state_t   : capture FSM encoding (IDLE, RUN, HALTED)
//   - *_W       : trace entry field widths; an entry is {pc, opcode, result}
//   - DROP_W    : width of the saturating overflow counter
//   - rotl1     : rotate-left-by-one helper used by the optional checksum
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int PC_W    = 8;
  localparam int OP_W    = 6;
  localparam int RES_W   = 32;
  localparam int ENTRY_W = PC_W + OP_W + RES_W;
  localparam int DROP_W  = 8;

  function automatic logic [RES_W-1:0] rotl1(input logic [RES_W-1:0] v);
    return {v[RES_W-2:0], v[RES_W-1]};
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// trace_capture_if: valid/ready drain port for trace entries.
//   rd_valid : producer -> consumer, head entry available
//   rd_ready : consumer -> producer, head entry accepted this cycle
//   rd_data  : producer -> consumer, head entry {pc, opcode, result}
// Modports: master (trace_capture side), slave (consumer side).
interface trace_capture_if import trace_pkg::*; ();

  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: show-ahead FIFO for trace entries.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous empty, wins over push and pop
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry, combinational from storage; holds the last
//                popped entry while empty (0 after reset)
//   count, full, empty : occupancy
module trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 46
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [WIDTH-1:0]  hold;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        hold   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trace_capture.sv
// trace_capture: records one entry per retired datapath instruction (a PC
// change) into a drainable FIFO and flags program end (PC parked in a loop).
//   clk, reset          : clock, asynchronous active-high reset
//   capture_en          : sample pc/opcode/result this cycle
//   clear               : synchronous flush to IDLE, highest priority
//   pc, opcode, result  : datapath outputs being observed
//   rd                  : valid/ready drain port (trace_capture_if.master)
//   count               : entries held
//   drop_cnt            : entries lost to overflow, saturating
//   halted              : HALT_CYCLES identical samples seen after last change
//   checksum            : only with TRACE_CHECKSUM_EN; rotl1(checksum)^result
//                         over every push request, including dropped ones
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HALT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture_en,
  input  logic               clear,
  input  logic [PC_W-1:0]    pc,
  input  logic [OP_W-1:0]    opcode,
  input  logic [RES_W-1:0]   result,
  trace_capture_if.master    rd,
  output logic [ADDR_W:0]    count,
  output logic [DROP_W-1:0]  drop_cnt,
`ifdef TRACE_CHECKSUM_EN
  output logic [RES_W-1:0]   checksum,
`endif
  output logic               halted
);

  localparam logic [7:0] STALL_ONE = 8'd1;
  localparam logic [7:0] HALT_LIM  = 8'(HALT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] prev_pc_q, prev_pc_d;
  logic [7:0]      stall_q, stall_d;
  logic            push_req;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_pc_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      prev_pc_q <= prev_pc_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_pc_d = prev_pc_q;
    stall_d   = stall_q;
    push_req  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      stall_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // First sample after reset/clear is always recorded.
          if (capture_en) begin
            push_req  = 1'b1;
            prev_pc_d = pc;
            stall_d   = '0;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (capture_en) begin
            if (pc != prev_pc_q) begin
              push_req  = 1'b1;
              prev_pc_d = pc;
              stall_d   = '0;
            end else if (stall_q == HALT_LIM) begin
              state_d = HALTED;
            end else begin
              stall_d = stall_q + STALL_ONE;
            end
          end
        end
        HALTED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign halted      = (state_q == HALTED);
  assign pop         = rd.rd_valid && rd.rd_ready;
  assign rd.rd_valid = !fifo_empty;

  trace_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (push_req),
    .pop   (pop),
    .din   ({pc, opcode, result}),
    .dout  (rd.rd_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (push_req && fifo_full && !pop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef TRACE_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (clear) begin
      checksum <= '0;
    end else if (push_req) begin
      checksum <= rotl1(checksum) ^ result;
    end
  end
`endif

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: scoreboard bench for trace_capture. The driver applies one
// cycle of stimulus per step, advances a behavioural model and queues the
// entries that must come out; a negedge monitor compares every drained entry.
module tb_trace_capture;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int HC = 4;

  logic clk = 1'b0;
  logic reset, capture_en, clear;
  logic [7:0]  pc;
  logic [5:0]  opcode;
  logic [31:0] result;
  logic [ADDR_W:0] count;
  logic [7:0]  drop_cnt;
  logic        halted;
`ifdef TRACE_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  trace_capture_if rd_if ();

  trace_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_CYCLES(HC)) dut (
    .clk        (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .clear      (clear),
    .pc         (pc),
    .opcode     (opcode),
    .result     (result),
    .rd         (rd_if),
    .count      (count),
    .drop_cnt   (drop_cnt),
`ifdef TRACE_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: expected FIFO contents plus the few facts the rules need.
  logic [45:0] exp_q[$];
  int          m_cnt;
  int          m_drop;
  bit          m_halted;
  bit          m_started;
  logic [7:0]  m_prev;
  int          m_same;
  logic [31:0] m_ck;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0; m_drop = 0; m_halted = 0; m_started = 0;
    m_prev = 8'd0; m_same = 0; m_ck = 32'd0;
  endtask

  // Checks outputs produced by the previous edge, drives this cycle, advances
  // the model, then waits until just after the next edge.
  task automatic step(input bit cap, input logic [7:0] p, input logic [5:0] op,
                      input logic [31:0] res, input bit rdy, input bit clr);
    bit pop, push_req;
    check("count", 64'(count), 64'(m_cnt));
    check("rd_valid", 64'(rd_if.rd_valid), 64'(m_cnt != 0));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("halted", 64'(halted), 64'(m_halted));
`ifdef TRACE_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(m_ck));
`endif
    capture_en = cap; pc = p; opcode = op; result = res;
    rd_if.rd_ready = rdy; clear = clr;
    if (clr) begin
      exp_q.delete();
      m_cnt = 0; m_drop = 0; m_halted = 0; m_started = 0; m_same = 0; m_ck = 0;
    end else begin
      pop = rdy && (m_cnt > 0);
      push_req = cap && !m_halted && (!m_started || p != m_prev);
      if (cap && !m_halted) begin
        if (push_req) begin
          m_started = 1; m_prev = p; m_same = 0;
        end else begin
          m_same++;
          if (m_same == HC) m_halted = 1;
        end
      end
      if (push_req) begin
        m_ck = {m_ck[30:0], m_ck[31]} ^ res;
        if (m_cnt == DEPTH && !pop) begin
          if (m_drop < 255) m_drop++;
        end else begin
          exp_q.push_back({p, op, res});
          m_cnt++;
        end
      end
      if (pop) m_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head entry must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && !clear && rd_if.rd_valid && rd_if.rd_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", 64'(rd_if.rd_data), 64'hdead);
      else check("rd_data", 64'(rd_if.rd_data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    reset = 1'b1; capture_en = 0; clear = 0; pc = 0; opcode = 0; result = 0;
    rd_if.rd_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_rd_data", 64'(rd_if.rd_data), 64'd0);

    // Four distinct PCs, no drain.
    for (int i = 0; i < 4; i++) step(1, 8'(i), 6'(i + 1), $urandom, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("head_pc", 64'(rd_if.rd_data[45:38]), 64'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);

    // Park on pc=2 until halt, then a new pc must not be recorded.
    step(0, 0, 0, 0, 0, 1);
    begin
      logic [7:0] seq [7] = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
      foreach (seq[i]) step(1, seq[i], 6'h11, $urandom, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    step(1, 8'd5, 6'h2a, $urandom, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

    // Overflow: 20 distinct PCs into 16 slots.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 8'(i), 6'(i), $urandom, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Full with a simultaneous pop: both happen, no drop.
    step(1, 8'd200, 6'h3f, 32'hcafe_f00d, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1, 0);

    // clear together with a push while halted, then IDLE pushes regardless of pc.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'd7, 6'd1, $urandom, 0, 0);
    step(1, 8'd7, 6'd2, $urandom, 0, 0);
    step(1, 8'd9, 6'd3, $urandom, 0, 1);
    step(1, 8'd7, 6'd4, $urandom, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 0);

    // Asynchronous reset in the low phase with five entries held.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(10 + i), 6'd5, $urandom, 0, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_valid", 64'(rd_if.rd_valid), 64'd0);
    capture_en = 0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 1; i <= 3; i++) step(1, 8'(i), 6'd6, 32'(i), 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

    // Randomised traffic with small PC range so halts and overflow both occur.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 5)), 6'($urandom),
           $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
